jtframe_rst_seq: RTL



---
 rtl/jtframe_rst_pkg.sv | 24 ++
 rtl/jtframe_sync_bit.sv | 24 ++
 rtl/jtframe_rst_seq.sv | 127 ++++++++++++
 3 files changed

// File: rtl/jtframe_rst_pkg.sv
// Shared types and sizing helpers for the ordered reset sequencer.
// Used by jtframe_rst_seq and its synchroniser sub-module.
package jtframe_rst_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } rst_state_e;

    localparam int LOST_W = 8;

    // The counter must reach the longest of the debounce, hold and stagger spans.
    function automatic int cnt_width(input int lock_db, input int hold,
                                     input int stagger, input int channels);
        int span;
        span = lock_db;
        if (hold > span) span = hold;
        if (stagger * (channels - 1) > span) span = stagger * (channels - 1);
        return $clog2(span + 1);
    endfunction

endpackage

// File: rtl/jtframe_sync_bit.sv
// Two-flop synchroniser for a single asynchronous level.
// Clears to 0 on rst_n so a lock or request is never seen during reset.
module jtframe_sync_bit
    import jtframe_rst_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            dout <= 1'b0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/jtframe_rst_seq.sv
// Debounced PLL-lock qualification followed by a staggered, ordered release
// of CHANNELS active-high resets; re-arms on lock loss or game reset request.
module jtframe_rst_seq
    import jtframe_rst_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int LOCK_DB  = 64,
    parameter int HOLD     = 16,
    parameter int STAGGER  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pll_locked,
    input  logic                game_rst,
    output logic [CHANNELS-1:0] rst_out,
    output logic                ready,
    output logic [LOST_W-1:0]   lost_cnt
);

    localparam int             CW        = cnt_width(LOCK_DB, HOLD, STAGGER, CHANNELS);
    localparam logic [CW-1:0]  CNT_MAX   = '1;
    localparam logic [CW-1:0]  LOCK_LAST = CW'(LOCK_DB - 1);
    localparam logic [CW-1:0]  HOLD_LAST = CW'(HOLD - 1);

    logic          lock_s;
    logic          req_s;
    rst_state_e    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;

    jtframe_sync_bit u_sync_lock (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (pll_locked),
        .dout (lock_s)
    );

    jtframe_sync_bit u_sync_req (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (game_rst),
        .dout (req_s)
    );

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

    // Channels still held in reset when the release counter is at c.
    function automatic logic [CHANNELS-1:0] held_mask(input logic [CW-1:0] c);
        logic [CHANNELS-1:0] m;
        int                  cv;
        cv = int'(c);
        for (int k = 0; k < CHANNELS; k++) begin
            m[k] = (cv < STAGGER * k);
        end
        return m;
    endfunction

    // State names are package-qualified because HOLD is also a parameter here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= jtframe_rst_pkg::WAIT_LOCK;
            cnt      <= '0;
            rst_out  <= '1;
            ready    <= 1'b0;
            lost_cnt <= '0;
        end else if (state != jtframe_rst_pkg::WAIT_LOCK && !lock_s) begin
            state   <= jtframe_rst_pkg::WAIT_LOCK;
            cnt     <= '0;
            rst_out <= '1;
            ready   <= 1'b0;
            if (lost_cnt != '1) lost_cnt <= lost_cnt + LOST_W'(1);
        end else begin
            unique case (state)
                jtframe_rst_pkg::WAIT_LOCK: begin
                    if (!lock_s) begin
                        cnt <= '0;
                    end else if (cnt == LOCK_LAST) begin
                        state <= jtframe_rst_pkg::HOLD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                jtframe_rst_pkg::HOLD: begin
                    if (req_s) begin
                        cnt <= '0;
                    end else if (cnt == HOLD_LAST) begin
                        state   <= jtframe_rst_pkg::RELEASE;
                        cnt     <= '0;
                        rst_out <= held_mask('0);
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                jtframe_rst_pkg::RELEASE: begin
                    if (req_s) begin
                        state   <= jtframe_rst_pkg::HOLD;
                        cnt     <= '0;
                        rst_out <= '1;
                        ready   <= 1'b0;
                    end else if (!rst_out[CHANNELS-1]) begin
                        state <= jtframe_rst_pkg::RUN;
                        ready <= 1'b1;
                    end else begin
                        cnt     <= cnt_inc;
                        rst_out <= rst_out & held_mask(cnt_inc);
                    end
                end
                jtframe_rst_pkg::RUN: begin
                    if (req_s) begin
                        state   <= jtframe_rst_pkg::HOLD;
                        cnt     <= '0;
                        rst_out <= '1;
                        ready   <= 1'b0;
                    end
                end
                default: begin
                    state   <= jtframe_rst_pkg::WAIT_LOCK;
                    cnt     <= '0;
                    rst_out <= '1;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

endmodule
